// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: requester bytes, uart_tx handshake and status shared by the scheduler and its environment
interface uart_tx_scheduler_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0] req_valid, req_last, req_ready, grant;
  logic [8*NUM_REQ-1:0] req_data;
  logic [7:0] data_to_tx;
  logic start_tx, tx_busy, busy, timeout_err;
  modport master(output req_valid, req_data, req_last, tx_busy, input req_ready, grant, data_to_tx, start_tx, busy, timeout_err);
  modport slave(input req_valid, req_data, req_last, tx_busy, output req_ready, grant, data_to_tx, start_tx, busy, timeout_err);
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin message scheduler sharing one uart_tx between NUM_REQ byte-stream requesters
module uart_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter bit HEADER_EN = 1'b1,
  parameter logic [5:0] HEADER_TAG = 6'b101010,
  parameter int START_TIMEOUT = 64
) (
  input logic clk,
  input logic reset,
  uart_tx_scheduler_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, WAIT_LO = 2'd2, FETCH = 2'd3;
  localparam int CW = $clog2(START_TIMEOUT + 1);
  logic [1:0] state, rr_ptr, winner, pick, next_ptr;
  logic [CW-1:0] cnt;
  logic last_flag, found, b_meta, busy_s, take;
  logic [NUM_REQ-1:0] win_oh, pick_oh;
  always_comb begin
    pick = rr_ptr;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (bus.req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        pick = 2'((int'(rr_ptr) + k) % NUM_REQ);
        found = 1'b1;
      end
  end
  assign next_ptr = (int'(winner) == NUM_REQ - 1) ? 2'd0 : winner + 2'd1;
  assign win_oh = NUM_REQ'(1) << winner;
  assign pick_oh = NUM_REQ'(1) << pick;
  assign take = state == IDLE && !busy_s && found;
  assign bus.req_ready = reset ? '0 :
                         (take && !HEADER_EN) ? pick_oh :
                         (state == FETCH && bus.req_valid[winner]) ? win_oh : '0;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) {busy_s, b_meta} <= 2'b00;
    else {busy_s, b_meta} <= {b_meta, bus.tx_busy};
  // start_tx only ever rises on entry to START, so uart_tx cannot re-trigger on a stale request
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      rr_ptr <= 2'd0;
      winner <= 2'd0;
      cnt <= '0;
      last_flag <= 1'b0;
      bus.grant <= '0;
      bus.data_to_tx <= 8'd0;
      bus.start_tx <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.timeout_err <= 1'b0;
      case (state)
        IDLE: if (take) begin
          winner <= pick;
          bus.grant <= pick_oh;
          bus.start_tx <= 1'b1;
          cnt <= '0;
          bus.data_to_tx <= HEADER_EN ? {HEADER_TAG, pick} : bus.req_data[8*int'(pick) +: 8];
          last_flag <= HEADER_EN ? 1'b0 : bus.req_last[pick];
          state <= START;
        end
        START: if (busy_s) begin
          bus.start_tx <= 1'b0;
          cnt <= '0;
          state <= WAIT_LO;
        end else if (cnt == CW'(START_TIMEOUT - 1)) begin
          bus.start_tx <= 1'b0;
          bus.timeout_err <= 1'b1;
          bus.grant <= '0;
          rr_ptr <= next_ptr;
          cnt <= '0;
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
        WAIT_LO: if (!busy_s) begin
          if (last_flag) begin
            rr_ptr <= next_ptr;
            bus.grant <= '0;
            state <= IDLE;
          end else state <= FETCH;
        end
        default: if (bus.req_valid[winner]) begin
          bus.data_to_tx <= bus.req_data[8*int'(winner) +: 8];
          last_flag <= bus.req_last[winner];
          bus.start_tx <= 1'b1;
          state <= START;
        end
      endcase
    end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Round-robin scheduler that shares one uart_tx instance between NUM_REQ byte-stream requesters. It grants the link to one requester for a whole message (bytes up to and including req_last) and optionally prefixes the message with a header byte carrying the source ID. It drives the uart_tx start_tx/data_to_tx handshake and watches tx_busy, which is generated in the uart_tx baud-clock domain.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..4, so the ID is 2 bits.
HEADER_EN, 1, 1 = send a header byte before each message; 0 = payload only.
HEADER_TAG, 6'b101010, upper 6 bits of the header byte; header = {HEADER_TAG, id[1:0]}.
START_TIMEOUT, 64, clk cycles allowed between start_tx assertion and synchronized tx_busy high.

Ports:
clk  in  1  system clock; same clock that feeds the uart_tx baud divider.
reset  in  1  asynchronous, active-high reset.
req_valid  in  NUM_REQ  per-requester byte available.
req_data  in  8*NUM_REQ  packed bytes; requester i occupies bits [8i+7:8i].
req_last  in  NUM_REQ  marks the current byte as the last byte of the message.
req_ready  out  NUM_REQ  one-cycle pulse: requester i's byte was accepted this cycle.
grant  out  NUM_REQ  one-hot; the requester that owns the link.
data_to_tx  out  8  byte to uart_tx; held stable while start_tx=1.
start_tx  out  1  request to uart_tx.
tx_busy  in  1  uart_tx busy flag; asynchronous to clk edges that matter.
busy  out  1  high whenever state != IDLE.
timeout_err  out  1  one-cycle pulse when a start times out.

Behaviour:
- Interface decision: one clock, clk; reset is asynchronous and active-high, port name reset.
- Reset values: req_ready=0, grant=0, data_to_tx=0, start_tx=0, busy=0, timeout_err=0.
- Reset state: rr_ptr=0, state=IDLE, both tx_busy synchronizer flops=0.
- tx_busy passes through a 2-flop synchronizer before use. busy_s is the synchronized value.
- States: IDLE, START, WAIT_LO, FETCH.
- IDLE:
  - Exit only when busy_s==0.
  - With at least one req_valid set, pick the first set bit searching from rr_ptr upward with wrap. Latch the winner index and set grant.
  - HEADER_EN=1: load data_to_tx with the header and set last_flag=0.
  - HEADER_EN=0: load the winner's req_data, pulse req_ready[winner] in the same cycle, and latch last_flag=req_last[winner].
  - Next state: START.
- START:
  - start_tx=1 and data_to_tx held constant. A timeout counter increments each cycle.
  - When busy_s==1: start_tx=0 the next cycle, clear the counter, go to WAIT_LO.
  - When the counter reaches START_TIMEOUT-1 with busy_s still 0:
    - Pulse timeout_err and drop start_tx.
    - Abort the message: grant=0, rr_ptr=winner+1 mod NUM_REQ, state=IDLE.
    - Bytes of that requester that were not accepted stay pending. They are sent as a new message when that requester is next granted.
- WAIT_LO: start_tx=0. On busy_s==0:
  - last_flag=1: rr_ptr=winner+1 mod NUM_REQ, grant=0, go to IDLE.
  - Otherwise go to FETCH.
- FETCH:
  - Wait for req_valid[winner]. Other requesters are ignored; there is no preemption.
  - On valid: latch data_to_tx=req_data[winner], pulse req_ready[winner], latch last_flag=req_last[winner], go to START.
- The header byte always has last_flag=0. A message therefore always contains at least one payload byte.
- start_tx is never high in WAIT_LO, FETCH or IDLE. This guarantees uart_tx never sees start_tx when it re-enters its IDLE, so no byte is duplicated.
- req_ready is only ever set for the granted index and is at most one cycle wide per accepted byte.
- Simultaneous events:
  - req_valid changing on the grant cycle: the value sampled at the IDLE edge wins.
  - req_valid from a non-granted requester: held off until the message ends.
- If tx_busy is high at reset release (uart_tx still initialising), IDLE waits for it to clear.
- Reset mid-operation asserts start_tx=0 immediately (asynchronous). Any byte already handed to uart_tx is that block's concern.

Test Plan:
1. NUM_REQ=4, HEADER_EN=1, req 2 sends bytes 0x55 then 0xC3 (last) -> uart_tx line carries 0xAA (header {101010,10}), 0x55, 0xC3; req_ready[2] pulses exactly twice; grant returns to 0.
2. All four req_valid held high, each sending 1-byte messages -> headers appear in ID order 0,1,2,3,0; rr_ptr wraps 3->0.
3. Req 1 mid-message (FETCH, req_valid[1]=0 for 100 cycles) while req 3 is valid -> no start_tx, grant stays 4'b0010; req 3 is served only after req 1's last byte.
4. tx_busy tied 0, START_TIMEOUT=64 -> start_tx high for exactly 64 cycles, one timeout_err pulse, busy falls, rr_ptr advances.
5. HEADER_EN=0, single byte 0x00 with req_last=1 -> req_ready pulses on the grant cycle; exactly one frame is sent; start_tx is deasserted within 3 clk of tx_busy rising.
6. Assert reset during START with start_tx=1 -> start_tx and grant go to 0 asynchronously; after release, IDLE resumes with rr_ptr=0.
